// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RISC-V pipeline registers: default widths,
// the NOP control word and the decode-to-execute payload bundle.
package riscv_pipe_pkg;

   localparam int XLEN_DEFAULT   = 32;
   localparam int CTRL_W_DEFAULT = 32;
   localparam int ALU_W_DEFAULT  = 4;

   localparam logic [CTRL_W_DEFAULT-1:0] CTRL_NOP = '0;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0]   instr;
      logic [XLEN_DEFAULT-1:0]   pc;
      logic [XLEN_DEFAULT-1:0]   npc;
      logic [CTRL_W_DEFAULT-1:0] ctrl;
      logic [ALU_W_DEFAULT-1:0]  alu_ctrl;
      logic [XLEN_DEFAULT-1:0]   imm;
      logic [XLEN_DEFAULT-1:0]   op_a;
      logic [XLEN_DEFAULT-1:0]   op_b;
   } id_ex_payload_t;

endpackage

// File: rtl/id_ex_slot.sv
// One payload register with a valid bit. Clear drops valid and forces the
// CLR_MASK bits of the payload to CLR_VAL; clear has priority over load.
module id_ex_slot #(
   parameter int             W        = 8,
   parameter logic [W-1:0]   CLR_MASK = '0,
   parameter logic [W-1:0]   CLR_VAL  = '0
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_clear,
   input  logic [W-1:0] i_d,
   output logic         o_valid,
   output logic [W-1:0] o_q
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // NOTE: the payload is reset as well as the valid bit, because the
   // outputs must read as all-zero after reset, not merely be ignored.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, regardless of statement order.
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
         r_data  <= (r_data & ~CLR_MASK) | (CLR_VAL & CLR_MASK);
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_d;
      end
   end

   assign o_valid = r_valid;
   assign o_q     = r_data;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with valid/ready, flush and stall counter.
// Define ID_EX_SKID_EN to add a 1-entry skid buffer that registers in_ready.
module id_ex_pipe_reg
   import riscv_pipe_pkg::*;
#(
   parameter int XLEN        = XLEN_DEFAULT,
   parameter int CTRL_W      = CTRL_W_DEFAULT,
   parameter int ALU_W       = ALU_W_DEFAULT,
   parameter int STALL_CNT_W = 16
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [XLEN-1:0]        in_instr,
   input  logic [XLEN-1:0]        in_pc,
   input  logic [XLEN-1:0]        in_npc,
   input  logic [XLEN-1:0]        in_imm,
   input  logic [XLEN-1:0]        in_op_a,
   input  logic [XLEN-1:0]        in_op_b,
   input  logic [CTRL_W-1:0]      in_ctrl,
   input  logic [ALU_W-1:0]       in_alu_ctrl,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_instr,
   output logic [XLEN-1:0]        out_pc,
   output logic [XLEN-1:0]        out_npc,
   output logic [XLEN-1:0]        out_imm,
   output logic [XLEN-1:0]        out_op_a,
   output logic [XLEN-1:0]        out_op_b,
   output logic [CTRL_W-1:0]      out_ctrl,
   output logic [ALU_W-1:0]       out_alu_ctrl,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam int PAY_W = 6*XLEN + CTRL_W + ALU_W;
   localparam int LOW_W = ALU_W + 3*XLEN;

   // Clearing a slot rewrites only the control field, so an invalid slot shows NOP.
   localparam logic [PAY_W-1:0] CTRL_MASK = {{(3*XLEN){1'b0}}, {CTRL_W{1'b1}}, {LOW_W{1'b0}}};
   localparam logic [PAY_W-1:0] CTRL_CLR  = {{(3*XLEN){1'b0}}, CTRL_W'(CTRL_NOP), {LOW_W{1'b0}}};

   logic [PAY_W-1:0]       w_in_pay;
   logic [PAY_W-1:0]       w_out_pay;
   logic [PAY_W-1:0]       w_out_d;
   logic                   w_out_valid;
   logic                   w_out_load;
   logic                   w_out_clear;
   logic                   w_in_xfer;
   logic                   w_out_xfer;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   assign w_in_pay   = {in_instr, in_pc, in_npc, in_ctrl, in_alu_ctrl, in_imm, in_op_a, in_op_b};
   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = w_out_valid && out_ready;

`ifdef ID_EX_SKID_EN
   logic             w_out_free;
   logic             w_skid_valid;
   logic [PAY_W-1:0] w_skid_pay;

   // Upstream sees only the registered skid state; the skid always drains first.
   assign w_out_free  = !w_out_valid || out_ready;
   assign in_ready    = !w_skid_valid;
   assign w_out_load  = !flush && w_out_free && (w_skid_valid || w_in_xfer);
   assign w_out_clear = flush || (w_out_xfer && !w_skid_valid && !w_in_xfer);
   assign w_out_d     = w_skid_valid ? w_skid_pay : w_in_pay;

   id_ex_slot #(.W(PAY_W), .CLR_MASK(CTRL_MASK), .CLR_VAL(CTRL_CLR)) u_skid_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (!flush && w_in_xfer && !w_out_free),
      .i_clear (flush || (w_skid_valid && w_out_free)),
      .i_d     (w_in_pay),
      .o_valid (w_skid_valid),
      .o_q     (w_skid_pay)
   );
`else
   assign in_ready    = !w_out_valid || out_ready;
   assign w_out_load  = w_in_xfer && !flush;
   assign w_out_clear = flush || (w_out_xfer && !w_in_xfer);
   assign w_out_d     = w_in_pay;
`endif

   id_ex_slot #(.W(PAY_W), .CLR_MASK(CTRL_MASK), .CLR_VAL(CTRL_CLR)) u_out_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_out_load),
      .i_clear (w_out_clear),
      .i_d     (w_out_d),
      .o_valid (w_out_valid),
      .o_q     (w_out_pay)
   );

   always_ff @(posedge clk) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (w_out_valid && !out_ready && !flush && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   assign out_valid = w_out_valid;
   assign stall_cnt = r_stall_cnt;
   assign {out_instr, out_pc, out_npc, out_ctrl, out_alu_ctrl, out_imm, out_op_a, out_op_b} = w_out_pay;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomised bench for id_ex_pipe_reg: the register is modelled as a FIFO of
// payloads (capacity 1, or 2 with ID_EX_SKID_EN) plus a saturating counter.
module tb_id_ex_pipe_reg;
   import riscv_pipe_pkg::*;

   localparam int XLEN   = XLEN_DEFAULT;
   localparam int CTRL_W = CTRL_W_DEFAULT;
   localparam int ALU_W  = ALU_W_DEFAULT;
   localparam int SCW    = 4;
   localparam int SAT    = (1 << SCW) - 1;

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, flush, out_valid, out_ready;
   id_ex_payload_t in_p, obs;
   logic [XLEN-1:0]   out_instr, out_pc, out_npc, out_imm, out_op_a, out_op_b;
   logic [CTRL_W-1:0] out_ctrl;
   logic [ALU_W-1:0]  out_alu_ctrl;
   logic [SCW-1:0]    stall_cnt;

   int total = 0;
   int bad   = 0;
   id_ex_payload_t mq[$];
   int m_cnt = 0;
   bit last_acc;

   always #5 clk = ~clk;

   id_ex_pipe_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .ALU_W(ALU_W), .STALL_CNT_W(SCW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_p.instr),
      .in_pc        (in_p.pc),
      .in_npc       (in_p.npc),
      .in_imm       (in_p.imm),
      .in_op_a      (in_p.op_a),
      .in_op_b      (in_p.op_b),
      .in_ctrl      (in_p.ctrl),
      .in_alu_ctrl  (in_p.alu_ctrl),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_instr    (out_instr),
      .out_pc       (out_pc),
      .out_npc      (out_npc),
      .out_imm      (out_imm),
      .out_op_a     (out_op_a),
      .out_op_b     (out_op_b),
      .out_ctrl     (out_ctrl),
      .out_alu_ctrl (out_alu_ctrl),
      .stall_cnt    (stall_cnt)
   );

   assign obs = {out_instr, out_pc, out_npc, out_ctrl, out_alu_ctrl, out_imm, out_op_a, out_op_b};

   function automatic bit m_ready();
`ifdef ID_EX_SKID_EN
      return mq.size() < 2;
`else
      return (mq.size() == 0) || out_ready;
`endif
   endfunction

   function automatic id_ex_payload_t rand_pay(input logic [XLEN-1:0] pc);
      id_ex_payload_t p;
      p.instr    = $urandom;
      p.pc       = pc;
      p.npc      = pc + 32'd4;
      p.ctrl     = $urandom | 32'h1;
      p.alu_ctrl = ALU_W'($urandom);
      p.imm      = $urandom;
      p.op_a     = $urandom;
      p.op_b     = $urandom;
      return p;
   endfunction

   // Advance one clock on DUT and model; returns at negedge + 1.
   task automatic cycle();
      bit ix, ox;
      ix = in_valid && m_ready();
      ox = (mq.size() > 0) && out_ready;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_cnt = 0;
      end else begin
         if (mq.size() > 0 && !out_ready && !flush && m_cnt < SAT) m_cnt++;
         if (flush) mq.delete();
         else begin
            if (ox) void'(mq.pop_front());
            if (ix) mq.push_back(in_p);
         end
      end
      last_acc = ix && !rst && !flush;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
      in_p = rand_pay(32'h0FC);
      cycle();
      rst = 1'b1; in_p = rand_pay(32'h100);
      cycle();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      total++;
      if (out_pc !== '0) begin bad++; $display("FAIL reset_pc: got %h want 0", out_pc); end
      total++;
      if (out_ctrl !== '0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", out_ctrl); end
      total++;
      if (stall_cnt !== '0) begin bad++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
      total++;
      if (obs !== '0) begin bad++; $display("FAIL reset_payload: got %h want 0", obs); end
      rst = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_stream();
      id_ex_payload_t exp;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_p = rand_pay(32'(i * 4));
         exp = in_p;
         cycle();
         total++;
         if (out_valid !== 1'b1 || out_pc !== 32'(i * 4))
            begin bad++; $display("FAIL stream_pc%0d: got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, i * 4); end
         total++;
         if (obs !== exp) begin bad++; $display("FAIL stream_payload%0d: got %h want %h", i, obs, exp); end
      end
      in_valid = 1'b0;
      cycle();
      total++;
      if (out_valid !== 1'b0 || out_ctrl !== '0)
         begin bad++; $display("FAIL stream_drain: got v=%b ctrl=%h want v=0 ctrl=0", out_valid, out_ctrl); end
   endtask

   task automatic test_stall();
      id_ex_payload_t p24;
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_p = rand_pay(32'h20);
      cycle();
      p24 = rand_pay(32'h24);
      in_p = p24; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++;
         if (in_ready !== m_ready())
            begin bad++; $display("FAIL stall_in_ready%0d: got %b want %b", k, in_ready, m_ready()); end
         cycle();
         if (last_acc) in_valid = 1'b0;
         total++;
         if (out_valid !== 1'b1 || out_pc !== 32'h20)
            begin bad++; $display("FAIL stall_hold%0d: got v=%b pc=%h want v=1 pc=20", k, out_valid, out_pc); end
      end
      total++;
      if (stall_cnt !== 4'd3) begin bad++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
      out_ready = 1'b1;
      cycle();
      if (last_acc) in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || obs !== p24)
         begin bad++; $display("FAIL stall_release: got v=%b %h want v=1 %h", out_valid, obs, p24); end
      total++;
      if (stall_cnt !== 4'd3) begin bad++; $display("FAIL stall_cnt_after: got %0d want 3", stall_cnt); end
      in_valid = 1'b0;
      cycle();
   endtask

   task automatic test_flush_stall();
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_p = rand_pay(32'h30);
      cycle();
      out_ready = 1'b0; in_p = rand_pay(32'h34);
      cycle();
      flush = 1'b1;
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0 || out_ctrl !== '0)
         begin bad++; $display("FAIL flush_out: got v=%b ctrl=%h want v=0 ctrl=0", out_valid, out_ctrl); end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
      total++;
      if (stall_cnt !== 4'd1) begin bad++; $display("FAIL flush_stall_cnt: got %0d want 1", stall_cnt); end
      out_ready = 1'b1;
      cycle();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_skid_empty: got v=%b want 0", out_valid); end
   endtask

   task automatic test_flush_input();
      flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_p = rand_pay(32'h40);
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_rdy_indep: got %b want 1", in_ready); end
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (out_valid !== 1'b0 || out_pc === 32'h40)
            begin bad++; $display("FAIL flush_drop%0d: got v=%b pc=%h want v=0 pc!=40", k, out_valid, out_pc); end
         cycle();
      end
   endtask

   task automatic test_saturation();
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_p = rand_pay(32'h50);
      cycle();
      in_valid = 1'b0; out_ready = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cycle();
         total++;
         if (stall_cnt !== SCW'((k < SAT) ? k : SAT))
            begin bad++; $display("FAIL sat_cnt%0d: got %0d want %0d", k, stall_cnt, (k < SAT) ? k : SAT); end
      end
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'h50)
         begin bad++; $display("FAIL sat_hold: got v=%b pc=%h want v=1 pc=50", out_valid, out_pc); end
      out_ready = 1'b1;
      cycle();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         in_p      = rand_pay($urandom);
         #1;
         total++;
         if (in_ready !== m_ready())
            begin bad++; $display("FAIL rnd_in_ready@%0d: got %b want %b", n, in_ready, m_ready()); end
         cycle();
         total++;
         if (out_valid !== (mq.size() > 0))
            begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", n, out_valid, mq.size() > 0); end
         total++;
         if (mq.size() > 0) begin
            if (obs !== mq[0]) begin bad++; $display("FAIL rnd_payload@%0d: got %h want %h", n, obs, mq[0]); end
         end else if (out_ctrl !== '0) begin
            bad++; $display("FAIL rnd_nop@%0d: got %h want 0", n, out_ctrl);
         end
         total++;
         if (stall_cnt !== SCW'(m_cnt))
            begin bad++; $display("FAIL rnd_stall@%0d: got %0d want %0d", n, stall_cnt, m_cnt); end
      end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_p = '0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_stall();
      test_flush_stall();
      test_flush_input();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised decode-to-execute pipeline register for the RISC-V core, replacing the fixed-width ID/EX latch. It carries instruction, PC, next-PC, control word, ALU control, immediate and both operands from decode to execute. It adds a valid/ready handshake for stalls, a synchronous flush that inserts a bubble, a saturating stall counter, and an optional skid buffer that registers the upstream ready.

## Interface
- XLEN, 32, width of instr/pc/npc/imm/operand fields
- CTRL_W, 32, control-word width
- ALU_W, 4, ALU control width
- STALL_CNT_W, 16, stall counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents a payload
- in_ready  out  1  register accepts payload this cycle
- in_instr, in_pc, in_npc, in_imm, in_op_a, in_op_b  in  XLEN each  decode payload
- in_ctrl  in  CTRL_W  control word
- in_alu_ctrl  in  ALU_W  ALU control
- flush  in  1  discard all held and incoming payloads (branch/exception redirect)
- out_valid  out  1  execute-side payload valid
- out_ready  in  1  execute consumes payload this cycle
- out_instr, out_pc, out_npc, out_imm, out_op_a, out_op_b  out  XLEN each  registered payload
- out_ctrl  out  CTRL_W  registered control word; CTRL_NOP when out_valid=0
- out_alu_ctrl  out  ALU_W  registered ALU control
- stall_cnt  out  STALL_CNT_W  saturating count of stalled cycles

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Reset (rst=1 at clk edge): out_valid=0, all payload outputs=0, out_ctrl=CTRL_NOP (0), stall_cnt=0, skid empty. Reset overrides flush and every transfer.
- Flush (rst=0, flush=1): out_valid<=0, out_ctrl<=CTRL_NOP, skid emptied. A same-cycle input transfer is dropped. Other payload fields hold their value (don't-care).
- Normal load: on an input transfer, every field is captured, including imm and both operands. out_valid<=1.
- Hold: if out_valid && !out_ready, all outputs stay unchanged.
- Drain: output transfer with no input transfer → out_valid<=0, out_ctrl<=CTRL_NOP.
- stall_cnt increments each cycle with out_valid && !out_ready && !flush. It saturates at all-ones and clears only on reset.

## Timing
- Latency: 1 cycle from input transfer to out_valid, in both configurations.
- Throughput: 1 payload/cycle while out_ready=1.
- Without skid, in_ready = !out_valid || out_ready. This is a combinational path from out_ready.
- in_ready does not depend on in_valid. It is independent of flush in the same cycle, but the payload is discarded on flush.
- Simultaneous input and output transfer: the new payload replaces the old one in the same edge, and out_valid stays 1.

## Configuration
- ID_EX_SKID_EN defined: a 1-entry skid buffer is added, and in_ready = !skid_valid (registered, with no path from out_ready).
  - An input transfer while the output is held fills the skid.
  - On the next output transfer, skid contents move to the output and the skid empties.
  - Ordering is strictly FIFO. Flush and reset empty the skid.
- ID_EX_SKID_EN undefined: there is no skid, and in_ready is combinational as above. The port list is identical in both builds.

## Structure
- Shared package riscv_pipe_pkg holds:
  - XLEN default
  - CTRL_W and ALU_W defaults
  - CTRL_NOP constant
  - packed struct id_ex_payload_t bundling all payload fields
- One sub-module, id_ex_slot: a payload register with load/clear enables. It is instantiated once for the output stage and once more for the skid when ID_EX_SKID_EN is defined.

## Test plan
- Reset mid-stream: hold rst=1 while in_valid=1 with pc=0x100 → next cycle out_valid=0, out_pc=0, out_ctrl=0, stall_cnt=0.
- Streaming: pc=0x0,0x4,0x8 on consecutive cycles with out_ready=1 → out_pc 0x0,0x4,0x8 one cycle later each. out_imm and out_op_a/out_op_b match the inputs exactly.
- Stall: load pc=0x20, then out_ready=0 for 3 cycles while presenting pc=0x24 → out_pc stays 0x20 and stall_cnt=3. After out_ready=1, 0x24 appears; with skid it arrives without re-presenting, without skid only after in_ready rises.
- Flush during stall: out_valid=1, out_ready=0, skid full, assert flush → next cycle out_valid=0, out_ctrl=0, skid empty, and in_ready=1.
- Flush with input: flush=1 and in_valid=1 with pc=0x40 in the same cycle → 0x40 never appears on the output.
- Saturation: STALL_CNT_W=4, stall for 20 cycles → stall_cnt holds at 15.
